// File: rtl/tomasulo_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tomasulo_pkg
// Description : Shared encodings for the Tomasulo dispatch slice: instruction
//               type codes, tag encode/decode helpers and default masks.
// Revision    : 1.0 - initial release
// ============================================================================
package tomasulo_pkg;

  // Instruction type codes; type k maps to functional-unit class k-1.
  typedef enum logic [3:0] {
    TYPE_ADD   = 4'd1,
    TYPE_MULT  = 4'd2,
    TYPE_FETCH = 4'd3,
    TYPE_STORE = 4'd4
  } inst_type_e;

  // Tag 0 means "no producer, read the register file".
  localparam int TAG_NONE = 0;

  // Per-class flag: 1 = class writes no destination (STORE).
  localparam logic [3:0] DEF_NO_DEST_MASK = 4'b1000;

  // Tag of reservation station idx inside class cls.
  function automatic int unsigned tag_encode(input int unsigned cls,
                                             input int unsigned idx,
                                             input int unsigned rs_per_class);
    return cls * rs_per_class + idx + 1;
  endfunction

  // Flat RS slot (0-based) addressed by a non-zero tag.
  function automatic int unsigned tag_decode(input int unsigned tag);
    return tag - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tomasulo_dispatch_rs_alloc.sv
`default_nettype none
// ============================================================================
// Module      : rs_alloc
// Description : Free-slot priority encoder for one RS class. The free vector
//               arrives already masked by claims of older lanes; the lowest
//               free index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_alloc #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     i_free,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx,
  output logic [N-1:0]     o_grant
);

  assign o_found = |i_free;
  // Isolate the lowest set bit as a one-hot grant.
  assign o_grant = i_free & (~i_free + N'(1));

  // Encode the lowest free index; scanning downward lets the lowest win.
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_free[i]) o_idx = IDX_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/tomasulo_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tomasulo_dispatch
// Description : N-lane in-order dispatch. Allocates reservation stations per
//               accepted lane, renames sources through the register status
//               table and retires RS/RST entries on CDB broadcasts.
// Revision    : 1.0 - initial release
// ============================================================================
module tomasulo_dispatch
  import tomasulo_pkg::*;
#(
  parameter int                   LANES        = 2,
  parameter int                   NUM_CLASS    = 4,
  parameter int                   RS_PER_CLASS = 2,
  parameter int                   NUM_REG      = 16,
  parameter int                   INS_PART_WID = 4,
  parameter int                   TAG_LEN      = 4,
  parameter logic [NUM_CLASS-1:0] NO_DEST_MASK = DEF_NO_DEST_MASK
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [LANES-1:0]                  inst_valid,
  input  logic [LANES*INS_PART_WID-1:0]     inst_type,
  input  logic [LANES*INS_PART_WID-1:0]     inst_dest,
  input  logic [LANES*INS_PART_WID-1:0]     inst_src0,
  input  logic [LANES*INS_PART_WID-1:0]     inst_src1,
  output logic [LANES-1:0]                  inst_fetch,
  output logic [LANES-1:0]                  disp_valid,
  output logic [LANES*TAG_LEN-1:0]          disp_rs,
  output logic [LANES*TAG_LEN-1:0]          disp_src0_tag,
  output logic [LANES*TAG_LEN-1:0]          disp_src1_tag,
  output logic [LANES-1:0]                  disp_illegal,
  input  logic                              cdb_valid,
  input  logic [TAG_LEN-1:0]                cdb_tag,
  output logic [NUM_CLASS*RS_PER_CLASS-1:0] rs_busy,
  output logic [NUM_REG-1:0]                reg_busy
);

  localparam int SLOTS = NUM_CLASS * RS_PER_CLASS;
  localparam int CLS_W = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
  localparam int IDX_W = (RS_PER_CLASS > 1) ? $clog2(RS_PER_CLASS) : 1;
  localparam int REG_W = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;

  // State
  logic [SLOTS-1:0]   rs_busy_q, rs_busy_d;
  logic [TAG_LEN-1:0] rst_tbl_q [NUM_REG];
  logic [TAG_LEN-1:0] rst_tbl_d [NUM_REG];
  logic [LANES-1:0]         disp_valid_q, disp_valid_d;
  logic [LANES-1:0]         disp_illegal_q, disp_illegal_d;
  logic [LANES*TAG_LEN-1:0] disp_rs_q, disp_rs_d;
  logic [LANES*TAG_LEN-1:0] disp_src0_q, disp_src0_d;
  logic [LANES*TAG_LEN-1:0] disp_src1_q, disp_src1_d;

  // Per-lane results gathered from the lane chain
  logic [LANES-1:0]         lane_acc, lane_alloc, lane_ill, lane_wr;
  logic [LANES*TAG_LEN-1:0] lane_tag;

  // CDB retirement: only a busy, in-range tag has any effect
  logic [SLOTS-1:0] cdb_clr;
  logic             cdb_hit;

  // Decode the CDB tag against currently busy stations.
  always_comb begin
    cdb_clr = '0;
    for (int t = 0; t < SLOTS; t++) begin
      cdb_clr[t] = cdb_valid && (cdb_tag == TAG_LEN'(t + 1)) && rs_busy_q[t];
    end
  end
  assign cdb_hit = |cdb_clr;

  // --------------------------------------------------------------------------
  // Lane chain: each lane sees the RS pool left over by older lanes and is
  // accepted only if every older lane was.
  // --------------------------------------------------------------------------
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [INS_PART_WID-1:0]    typ, dst, src0, src1;
    logic                       illegal;
    logic [CLS_W-1:0]           cls;
    logic [SLOTS-1:0]           avail_in, avail_out, grant_all, claim;
    logic [NUM_CLASS-1:0]       found;
    logic [NUM_CLASS*IDX_W-1:0] idx_all;
    logic                       prev_ok, accept, alloc, found_sel;
    logic [IDX_W-1:0]           idx_sel;

    assign typ  = inst_type[l*INS_PART_WID +: INS_PART_WID];
    assign dst  = inst_dest[l*INS_PART_WID +: INS_PART_WID];
    assign src0 = inst_src0[l*INS_PART_WID +: INS_PART_WID];
    assign src1 = inst_src1[l*INS_PART_WID +: INS_PART_WID];

    assign illegal = (typ == '0) || (32'(typ) > NUM_CLASS) ||
                     (32'(dst) >= NUM_REG) || (32'(src0) >= NUM_REG) ||
                     (32'(src1) >= NUM_REG);
    assign cls = CLS_W'(typ - INS_PART_WID'(1));

    if (l == 0) begin : g_head
      assign avail_in = ~rs_busy_q;
      assign prev_ok  = 1'b1;
    end else begin : g_chain
      assign avail_in = g_lane[l-1].avail_out;
      assign prev_ok  = g_lane[l-1].accept;
    end

    for (genvar c = 0; c < NUM_CLASS; c++) begin : g_cls
      rs_alloc #(
        .N     (RS_PER_CLASS),
        .IDX_W (IDX_W)
      ) u_rs_alloc (
        .i_free  (avail_in[c*RS_PER_CLASS +: RS_PER_CLASS]),
        .o_found (found[c]),
        .o_idx   (idx_all[c*IDX_W +: IDX_W]),
        .o_grant (grant_all[c*RS_PER_CLASS +: RS_PER_CLASS])
      );
    end

    // Pick this lane's class result, decide acceptance and claim the slot.
    always_comb begin
      found_sel = 1'b0;
      idx_sel   = '0;
      claim     = '0;
      for (int c = 0; c < NUM_CLASS; c++) begin
        if (cls == CLS_W'(c)) begin
          found_sel = found[c];
          idx_sel   = idx_all[c*IDX_W +: IDX_W];
        end
      end
      accept = inst_valid[l] && prev_ok && (illegal || found_sel);
      alloc  = accept && !illegal;
      for (int c = 0; c < NUM_CLASS; c++) begin
        if (alloc && (cls == CLS_W'(c))) begin
          claim[c*RS_PER_CLASS +: RS_PER_CLASS] = grant_all[c*RS_PER_CLASS +: RS_PER_CLASS];
        end
      end
    end

    assign avail_out = avail_in & ~claim;

    assign lane_acc[l]   = accept;
    assign lane_alloc[l] = alloc;
    assign lane_ill[l]   = accept && illegal;
    assign lane_wr[l]    = alloc && !NO_DEST_MASK[cls];
    assign lane_tag[l*TAG_LEN +: TAG_LEN] =
      TAG_LEN'(tag_encode(32'(cls), 32'(idx_sel), RS_PER_CLASS));
  end

  assign inst_fetch = lane_acc;

  // Producer tag for a source of a lane: RST, then youngest older in-bundle
  // writer, then zeroed if the producer is completing on the CDB right now.
  function automatic logic [TAG_LEN-1:0] rename_src(input int lane,
                                                    input logic [INS_PART_WID-1:0] src);
    logic [TAG_LEN-1:0] t;
    t = rst_tbl_q[src[REG_W-1:0]];
    for (int j = 0; j < LANES; j++) begin
      if ((j < lane) && lane_wr[j] &&
          (inst_dest[j*INS_PART_WID +: INS_PART_WID] == src)) begin
        t = lane_tag[j*TAG_LEN +: TAG_LEN];
      end
    end
    if (cdb_hit && (t == cdb_tag)) t = TAG_LEN'(TAG_NONE);
    return t;
  endfunction

  // Dispatch outputs for the next cycle.
  always_comb begin
    disp_valid_d   = lane_alloc;
    disp_illegal_d = lane_ill;
    disp_rs_d      = '0;
    disp_src0_d    = '0;
    disp_src1_d    = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_alloc[i]) begin
        disp_rs_d[i*TAG_LEN +: TAG_LEN]   = lane_tag[i*TAG_LEN +: TAG_LEN];
        disp_src0_d[i*TAG_LEN +: TAG_LEN] = rename_src(i, inst_src0[i*INS_PART_WID +: INS_PART_WID]);
        disp_src1_d[i*TAG_LEN +: TAG_LEN] = rename_src(i, inst_src1[i*INS_PART_WID +: INS_PART_WID]);
      end
    end
  end

  // Next RS occupancy and RST: CDB clears first, dispatch writes override.
  always_comb begin
    rs_busy_d = (rs_busy_q & ~cdb_clr) | (~rs_busy_q & ~g_lane[LANES-1].avail_out);
    for (int r = 0; r < NUM_REG; r++) begin
      rst_tbl_d[r] = rst_tbl_q[r];
      if (cdb_hit && (rst_tbl_q[r] == cdb_tag)) rst_tbl_d[r] = TAG_LEN'(TAG_NONE);
      for (int j = 0; j < LANES; j++) begin
        if (lane_wr[j] && (inst_dest[j*INS_PART_WID +: INS_PART_WID] == INS_PART_WID'(r))) begin
          rst_tbl_d[r] = lane_tag[j*TAG_LEN +: TAG_LEN];
        end
      end
    end
  end

  // State registers; reset overrides any concurrent CDB or dispatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_busy_q      <= '0;
      disp_valid_q   <= '0;
      disp_illegal_q <= '0;
      disp_rs_q      <= '0;
      disp_src0_q    <= '0;
      disp_src1_q    <= '0;
      for (int r = 0; r < NUM_REG; r++) rst_tbl_q[r] <= '0;
    end else begin
      rs_busy_q      <= rs_busy_d;
      disp_valid_q   <= disp_valid_d;
      disp_illegal_q <= disp_illegal_d;
      disp_rs_q      <= disp_rs_d;
      disp_src0_q    <= disp_src0_d;
      disp_src1_q    <= disp_src1_d;
      for (int r = 0; r < NUM_REG; r++) rst_tbl_q[r] <= rst_tbl_d[r];
    end
  end

  // Register-busy view of the RST.
  always_comb begin
    reg_busy = '0;
    for (int r = 0; r < NUM_REG; r++) reg_busy[r] = |rst_tbl_q[r];
  end

  assign rs_busy       = rs_busy_q;
  assign disp_valid    = disp_valid_q;
  assign disp_illegal  = disp_illegal_q;
  assign disp_rs       = disp_rs_q;
  assign disp_src0_tag = disp_src0_q;
  assign disp_src1_tag = disp_src1_q;

endmodule
`default_nettype wire
